// File: rtl/reflector_pkg.sv
// Shared constants, state type and default-table helper for the programmable reflector.
package reflector_pkg;

  localparam int ALPHABET = 26;

  // Partner index for each letter of the classic 26-letter reflector wiring.
  localparam int DEFAULT_26 [ALPHABET] = '{
    16, 24,  7, 14,  6, 13,  4,  2, 21, 15, 20, 25, 19,
     5,  3,  9,  0, 23, 22, 12, 10,  8, 18, 17,  1, 11
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_e;

  // Entry i of the power-up pairing table for an alphabet of n letters.
  function automatic int default_partner(input int n, input int i);
    if (n == ALPHABET) return DEFAULT_26[i[4:0]];
    return i ^ 1;
  endfunction

endpackage

// File: rtl/reflector_if.sv
// Configuration port of the reflector: pair beats, commit/abort requests and completion status.
interface reflector_if
  import reflector_pkg::*;
#(
  parameter int N    = ALPHABET,
  parameter int IDXW = $clog2(N)
);

  logic            cfg_valid;
  logic            cfg_ready;
  logic [IDXW-1:0] cfg_a;
  logic [IDXW-1:0] cfg_b;
  logic            cfg_commit;
  logic            cfg_abort;
  logic            cfg_done;
  logic            cfg_err;

  modport master (
    output cfg_valid, cfg_a, cfg_b, cfg_commit, cfg_abort,
    input  cfg_ready, cfg_done, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_a, cfg_b, cfg_commit, cfg_abort,
    output cfg_ready, cfg_done, cfg_err
  );

endinterface

// File: rtl/reflector_map.sv
// One-hot lane permutation through a partner table; multi-hot inputs OR their mapped lanes.
module reflector_map #(
  parameter int N    = 26,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]           i_in,
  input  logic [N-1:0][IDXW-1:0] i_table,
  output logic [N-1:0]           o_out
);

  always_comb begin
    o_out = '0;
    for (int i = 0; i < N; i++) begin
      if (i_in[i]) o_out[i_table[i]] = 1'b1;
    end
  end

endmodule

// File: rtl/programmable_reflector.sv
// Run-time rewirable reflector: edits are staged in a shadow table and copied to the active table on commit.
// Define REFLECTOR_CHECK_EN to verify the staged table is a fixed-point-free involution before applying it.
module programmable_reflector
  import reflector_pkg::*;
#(
  parameter int N    = ALPHABET,
  parameter int IDXW = $clog2(N)
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [N-1:0] in,
  output logic [N-1:0] out,
  reflector_if.slave   cfg
);

  typedef logic [N-1:0][IDXW-1:0] table_t;

  function automatic table_t build_default();
    for (int i = 0; i < N; i++) build_default[i] = IDXW'(default_partner(N, i));
  endfunction

  localparam table_t DEFAULT_TABLE = build_default();

  state_e r_state, w_state_nxt;
  table_t r_active, r_shadow;
  logic   r_done, r_err;
  logic   w_range_ok, w_beat_wr, w_commit, w_restore, w_apply, w_fail, w_busy;

`ifdef REFLECTOR_CHECK_EN
  logic [IDXW-1:0] r_idx, w_partner;
  logic            r_bad, w_bad_set, w_entry_ok;

  assign w_partner  = r_shadow[r_idx];
  assign w_entry_ok = (r_shadow[w_partner] == r_idx) && (w_partner != r_idx);
  assign w_busy     = (r_state == CHECK);
`else
  logic r_pend;

  assign w_busy = r_pend;
`endif

  assign w_range_ok = (int'(cfg.cfg_a) < N) && (int'(cfg.cfg_b) < N);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_wr   = 1'b0;
    w_commit    = 1'b0;
    w_restore   = 1'b0;
    w_apply     = 1'b0;
    w_fail      = 1'b0;
`ifdef REFLECTOR_CHECK_EN
    w_bad_set   = 1'b0;
`endif
    if (w_busy) begin
`ifdef REFLECTOR_CHECK_EN
      if ((r_bad && r_idx == '0) || !w_entry_ok) begin
        w_fail      = 1'b1;
        w_restore   = 1'b1;
        w_state_nxt = IDLE;
      end else if (r_idx == IDXW'(N - 1)) begin
        w_apply     = 1'b1;
        w_state_nxt = IDLE;
      end
`else
      w_apply     = 1'b1;
      w_state_nxt = IDLE;
`endif
    end else if (cfg.cfg_abort) begin
      // Abort outranks any beat or commit presented alongside it.
      w_restore   = 1'b1;
      w_state_nxt = IDLE;
    end else begin
      if (cfg.cfg_valid) begin
        w_beat_wr   = w_range_ok;
`ifdef REFLECTOR_CHECK_EN
        w_bad_set   = !w_range_ok;
`endif
        w_state_nxt = LOAD;
      end
      if (cfg.cfg_commit) begin
        w_commit    = 1'b1;
`ifdef REFLECTOR_CHECK_EN
        w_state_nxt = CHECK;
`endif
      end
    end
  end

  // NOTE: both tables are small flop arrays rather than a RAM, so they can and must reset to the default wiring.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_active <= DEFAULT_TABLE;
      r_shadow <= DEFAULT_TABLE;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking, so active and shadow read each other's pre-edge contents when copied.
      r_state <= w_state_nxt;
      r_done  <= w_apply | w_fail;
      r_err   <= w_fail;
      if (w_apply) r_active <= r_shadow;
      if (w_restore) begin
        r_shadow <= r_active;
      end else if (w_beat_wr) begin
        r_shadow[cfg.cfg_a] <= cfg.cfg_b;
        r_shadow[cfg.cfg_b] <= cfg.cfg_a;
      end
    end
  end

`ifdef REFLECTOR_CHECK_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_idx <= '0;
      r_bad <= 1'b0;
    end else begin
      if (w_commit) r_idx <= '0;
      else if (w_busy) r_idx <= r_idx + 1'b1;
      if (w_restore) r_bad <= 1'b0;
      else if (w_bad_set) r_bad <= 1'b1;
    end
  end
`else
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_pend <= 1'b0;
    else r_pend <= w_commit;
  end
`endif

  assign cfg.cfg_ready = !w_busy;
  assign cfg.cfg_done  = r_done;
  assign cfg.cfg_err   = r_err;

  reflector_map #(.N(N), .IDXW(IDXW)) u_map (
    .i_in    (in),
    .i_table (r_active),
    .o_out   (out)
  );

endmodule

// File: tb/tb_programmable_reflector.sv
// Directed plus randomized bench for programmable_reflector against a letter-pair reference model.
module tb_programmable_reflector;

  localparam int N = 26;
  localparam int W = $clog2(N);

  logic         clock = 1'b0;
  logic         resetn = 1'b1;
  logic [N-1:0] in_vec = '0;
  logic [N-1:0] out_vec;
  logic [N-1:0] v;
  int           checks = 0;
  int           failures = 0;
  int           act [N];
  int           shd [N];
  bit           bad;
  int           perm [N];
  bit           saw_done;

  reflector_if #(.N(N)) cfg_bus ();

  programmable_reflector #(.N(N)) dut (
    .clock  (clock),
    .resetn (resetn),
    .in     (in_vec),
    .out    (out_vec),
    .cfg    (cfg_bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_bus.cfg_valid  = 1'b0;
    cfg_bus.cfg_commit = 1'b0;
    cfg_bus.cfg_abort  = 1'b0;
    cfg_bus.cfg_a      = '0;
    cfg_bus.cfg_b      = '0;
  endtask

  task automatic model_reset();
    string pairs = "AQBYCHDOEGFNIVJPKULZMTRXSW";
    int a, b;
    for (int k = 0; k < N; k += 2) begin
      a = int'(pairs[k]) - 65;
      b = int'(pairs[k + 1]) - 65;
      act[a] = b;
      act[b] = a;
    end
    shd = act;
    bad = 1'b0;
  endtask

  function automatic logic [N-1:0] model_map(input logic [N-1:0] x);
    model_map = '0;
    for (int i = 0; i < N; i++) if (x[i]) model_map[act[i]] = 1'b1;
  endfunction

  task automatic model_beat(input int a, input int b);
    if (a < N && b < N) begin
      shd[a] = b;
      shd[b] = a;
    end else begin
`ifdef REFLECTOR_CHECK_EN
      bad = 1'b1;
`endif
    end
  endtask

  task automatic check_map(input string tag, input logic [N-1:0] x);
    in_vec = x;
    #1;
    check(tag, out_vec, model_map(x));
  endtask

  task automatic send(input int a, input int b);
    model_beat(a, b);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_a     = W'(a);
    cfg_bus.cfg_b     = W'(b);
    tick();
    idle_inputs();
  endtask

  task automatic do_abort();
    shd = act;
    bad = 1'b0;
    cfg_bus.cfg_abort = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    #1;
    model_reset();
    check("reset ready", cfg_bus.cfg_ready, 1);
    check("reset done", cfg_bus.cfg_done, 0);
    check("reset err", cfg_bus.cfg_err, 0);
    check_map("reset map A", N'(1));
    resetn = 1'b1;
    tick();
  endtask

  task automatic do_commit(input string tag, input bit with_beat = 1'b0, input int a = 0, input int b = 0);
    int exp_lat, lat;
    bit exp_err, seen;
    if (with_beat) model_beat(a, b);
`ifdef REFLECTOR_CHECK_EN
    exp_lat = N;
    exp_err = 1'b0;
    if (bad) begin
      exp_lat = 1;
      exp_err = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (shd[shd[i]] != i || shd[i] == i) begin
          exp_lat = i + 1;
          exp_err = 1'b1;
          break;
        end
      end
    end
`else
    exp_lat = 1;
    exp_err = 1'b0;
`endif
    if (exp_err) shd = act;
    else act = shd;
    bad = 1'b0;
    cfg_bus.cfg_valid  = with_beat;
    cfg_bus.cfg_a      = W'(a);
    cfg_bus.cfg_b      = W'(b);
    cfg_bus.cfg_commit = 1'b1;
    tick();
    idle_inputs();
    check({tag, " busy"}, cfg_bus.cfg_ready, 0);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < N + 4) begin
      tick();
      lat++;
      if (cfg_bus.cfg_done === 1'b1) seen = 1'b1;
    end
    check({tag, " done seen"}, seen, 1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " err"}, cfg_bus.cfg_err, exp_err);
    tick();
    check({tag, " done pulse"}, cfg_bus.cfg_done, 0);
    check({tag, " ready"}, cfg_bus.cfg_ready, 1);
  endtask

  task automatic shuffle();
    int j, t;
    for (int i = 0; i < N; i++) perm[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(i);
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    tick();

    // Reset mapping and a few directed lanes.
    do_reset();
    check_map("A to Q", N'(1) << 0);
    check_map("Q to A", N'(1) << 16);
    check_map("E to G", N'(1) << 4);
    check_map("zero in", '0);
    for (int k = 0; k < 4; k++) begin
      v = N'($urandom());
      check_map("multi-hot default", v);
    end

    // Adjacent-pair table.
    for (int k = 0; k < N; k += 2) send(k, k + 1);
    do_commit("adjacent");
    check_map("adjacent A", N'(1) << 0);
    check_map("adjacent Z", N'(1) << 25);

    // Fixed point.
    do_reset();
    send(4, 4);
    do_commit("fixed point");
    check_map("fixed point E", N'(1) << 4);
    check_map("fixed point G", N'(1) << 6);

    // Lone swap leaves stale partners, then repaired.
    do_reset();
    send(0, 2);
    do_commit("lone swap");
    send(0, 2);
    send(16, 7);
    do_commit("swap repaired");
    check_map("swap A", N'(1) << 0);
    check_map("swap H", N'(1) << 7);

    // Abort discards staged edits; abort beats a simultaneous beat and commit.
    do_reset();
    send(0, 1);
    do_abort();
    do_commit("after abort");
    check_map("abort A", N'(1) << 0);
    shd = act;
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_a      = W'(0);
    cfg_bus.cfg_b      = W'(1);
    cfg_bus.cfg_commit = 1'b1;
    cfg_bus.cfg_abort  = 1'b1;
    tick();
    idle_inputs();
    check("abort wins ready", cfg_bus.cfg_ready, 1);
    saw_done = 1'b0;
    for (int k = 0; k < N + 2; k++) begin
      tick();
      if (cfg_bus.cfg_done !== 1'b0) saw_done = 1'b1;
    end
    check("abort wins no done", saw_done, 0);
    check_map("abort wins A", N'(1) << 0);

    // Out-of-range beat, then a clean commit.
    send(26, 3);
    do_commit("out of range");
    check_map("out of range D", N'(1) << 3);
    do_commit("bad cleared");

    // Random valid pairing; last beat rides with the commit.
    shuffle();
    for (int k = 0; k < N - 2; k += 2) send(perm[k], perm[k + 1]);
    do_commit("random pairs", 1'b1, perm[N - 2], perm[N - 1]);
    for (int k = 0; k < 6; k++) begin
      v = N'($urandom());
      check_map("multi-hot random", v);
    end
    v = '0;
    v[$urandom_range(N - 1)] = 1'b1;
    check_map("one-hot random", v);

    // Reset during the commit scan: no completion pulse, default mapping back.
    shuffle();
    for (int k = 0; k < N - 2; k += 2) send(perm[k], perm[k + 1]);
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_a      = W'(perm[N - 2]);
    cfg_bus.cfg_b      = W'(perm[N - 1]);
    cfg_bus.cfg_commit = 1'b1;
    tick();
    idle_inputs();
`ifdef REFLECTOR_CHECK_EN
    for (int k = 0; k < 3; k++) tick();
`endif
    resetn = 1'b0;
    #1;
    model_reset();
    check("mid reset ready", cfg_bus.cfg_ready, 1);
    check("mid reset done", cfg_bus.cfg_done, 0);
    check_map("mid reset A", N'(1) << 0);
    #1;
    resetn = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < N + 3; k++) begin
      tick();
      if (cfg_bus.cfg_done !== 1'b0) saw_done = 1'b1;
    end
    check("mid reset no done", saw_done, 0);
    check_map("post reset Q", N'(1) << 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
